// File: rtl/nco_time_cnt_if.sv
// Control/status bundle for nco_time_cnt: NCO divisor, run/load controls,
// load and alarm values in; tick, time fields, day pulse and alarm flag out.
interface nco_time_cnt_if #(
  parameter int NCO_W = 32,
  parameter int CW    = 6
) ();
  logic [NCO_W-1:0] num;
  logic             run;
  logic             load;
  logic [CW-1:0]    ld_sec;
  logic [CW-1:0]    ld_min;
  logic [CW-1:0]    ld_hour;
  logic [CW-1:0]    alarm_sec;
  logic [CW-1:0]    alarm_min;
  logic [CW-1:0]    alarm_hour;
  logic             alarm_clr;
  logic             tick_o;
  logic [CW-1:0]    sec;
  logic [CW-1:0]    min;
  logic [CW-1:0]    hour;
  logic             day_o;
  logic             alarm_o;

  modport master (
    output num, run, load, ld_sec, ld_min, ld_hour,
           alarm_sec, alarm_min, alarm_hour, alarm_clr,
    input  tick_o, sec, min, hour, day_o, alarm_o
  );

  modport slave (
    input  num, run, load, ld_sec, ld_min, ld_hour,
           alarm_sec, alarm_min, alarm_hour, alarm_clr,
    output tick_o, sec, min, hour, day_o, alarm_o
  );
endinterface

// File: rtl/nco_time_cnt.sv
// NCO tick enable driving a cascaded sec/min/hour chain, single clock domain.
// Optional sticky alarm compare is built when macro ALARM_EN is defined.
module nco_time_cnt #(
  parameter int NCO_W    = 32,
  parameter int CW       = 6,
  parameter int SEC_MOD  = 60,
  parameter int MIN_MOD  = 60,
  parameter int HOUR_MOD = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  nco_time_cnt_if.slave bus
);

  logic [NCO_W-1:0] cnt_reg;
  logic [NCO_W-1:0] lim;
  logic             tick_reg;
  logic             day_reg;
  logic [CW-1:0]    field [3];
  logic [CW-1:0]    ld_val [3];
  logic [3:0]       carry;

  // num of 0 and 1 both collapse to a terminal count of 0 (tick every cycle)
  assign lim = (bus.num == '0) ? '0 : bus.num - NCO_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (bus.load) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (bus.run) begin
      if (cnt_reg >= lim) begin
        cnt_reg  <= '0;
        tick_reg <= 1'b1;
      end else begin
        cnt_reg  <= cnt_reg + NCO_W'(1);
        tick_reg <= 1'b0;
      end
    end else begin
      tick_reg <= 1'b0;
    end
  end

  assign ld_val[0] = bus.ld_sec;
  assign ld_val[1] = bus.ld_min;
  assign ld_val[2] = bus.ld_hour;
  assign carry[0]  = tick_reg;

  // Stage gi advances when every lower stage wraps in the same tick cycle
  for (genvar gi = 0; gi < 3; gi++) begin : g_stage
    localparam int STAGE_MOD = (gi == 0) ? SEC_MOD : (gi == 1) ? MIN_MOD : HOUR_MOD;
    logic [CW-1:0] val_reg;
    logic          wrap;

    assign wrap          = (val_reg >= CW'(STAGE_MOD - 1));
    assign carry[gi + 1] = carry[gi] & wrap;
    assign field[gi]     = val_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        val_reg <= '0;
      else if (bus.load)
        val_reg <= ld_val[gi];
      else if (carry[gi])
        val_reg <= wrap ? '0 : val_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      day_reg <= 1'b0;
    else
      day_reg <= carry[3] & ~bus.load;
  end

  assign bus.tick_o = tick_reg;
  assign bus.sec    = field[0];
  assign bus.min    = field[1];
  assign bus.hour   = field[2];
  assign bus.day_o  = day_reg;

`ifdef ALARM_EN
  logic upd_reg;
  logic alarm_reg;
  logic match;

  assign match = (field[0] == bus.alarm_sec) && (field[1] == bus.alarm_min) &&
                 (field[2] == bus.alarm_hour);

  // Compare only right after the fields change, so a held match fires once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_reg   <= 1'b0;
      alarm_reg <= 1'b0;
    end else begin
      upd_reg <= bus.load | tick_reg;
      if (bus.alarm_clr)
        alarm_reg <= 1'b0;
      else if (upd_reg && match)
        alarm_reg <= 1'b1;
    end
  end

  assign bus.alarm_o = alarm_reg;
`else
  logic unused_alarm;
  assign unused_alarm = ^{bus.alarm_sec, bus.alarm_min, bus.alarm_hour, bus.alarm_clr};
  assign bus.alarm_o  = 1'b0;
`endif

endmodule
